box_drawer: RTL and testbench

- Downstream stage of the symbol drawer.
- Accepts one box request per gobox/donebox handshake: origin, colour and side length.
- Rasterises an N×N filled square, one pixel per clock, onto the VGA adapter's pixel-write port (x, y, colour, plot).
- Clips pixels that fall outside the 160×120 screen.

---
 rtl/box_pkg.sv | 10 +
 rtl/box_scan_counter.sv | 32 +++
 rtl/box_drawer.sv | 99 +++++++++
 tb/tb_box_drawer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/box_pkg.sv
// box_pkg: shared widths, screen defaults and FSM state type for the box drawer
package box_pkg;
  localparam int X_W          = 8;
  localparam int Y_W          = 7;
  localparam int CLR_W        = 3;
  localparam int SCALE_W      = 6;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
endpackage

// File: rtl/box_scan_counter.sv
// box_scan_counter: row-major cx/cy walker over an N x N box with last-pixel flag
module box_scan_counter
  import box_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [SCALE_W-1:0] i_n,
  output logic [SCALE_W-1:0] o_cx,
  output logic [SCALE_W-1:0] o_cy,
  output logic               o_last
);
  logic [SCALE_W-1:0] r_cx, r_cy;
  logic               w_row_end;
  assign w_row_end = r_cx == i_n - SCALE_W'(1);
  assign o_last    = w_row_end && (r_cy == i_n - SCALE_W'(1));
  assign o_cx      = r_cx;
  assign o_cy      = r_cy;
  // x advances every enabled cycle, wrapping to the next row at the side length
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (i_clr) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (i_en) begin
      r_cx <= w_row_end ? '0 : r_cx + SCALE_W'(1);
      r_cy <= w_row_end ? r_cy + SCALE_W'(1) : r_cy;
    end
endmodule

// File: rtl/box_drawer.sv
// box_drawer: rasterises an N x N filled box one pixel per clock; BOX_CLIP_EN enables screen clipping
module box_drawer
  import box_pkg::*;
`ifdef BOX_CLIP_EN
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
)
`endif
(
  input  logic               clk,
  input  logic               reset,
  input  logic [X_W-1:0]     Xin,
  input  logic [Y_W-1:0]     Yin,
  input  logic [CLR_W-1:0]   Clrin,
  input  logic [SCALE_W-1:0] Scalein,
  input  logic               gobox,
  output logic               donebox,
  output logic               busy,
  output logic [X_W-1:0]     Xvga,
  output logic [Y_W-1:0]     Yvga,
  output logic [CLR_W-1:0]   Clrvga,
  output logic               plot
);
  state_t             r_state, w_state_nxt;
  logic [X_W-1:0]     r_xb;
  logic [Y_W-1:0]     r_yb;
  logic [CLR_W-1:0]   r_cb;
  logic [SCALE_W-1:0] r_nb;
  logic [SCALE_W-1:0] w_cx, w_cy;
  logic               w_last, w_accept, w_en, w_on;
  logic [X_W-1:0]     w_x;
  logic [Y_W-1:0]     w_y;
  assign w_accept = (r_state == IDLE) && gobox;
  assign w_en     = r_state == DRAW;
`ifdef BOX_CLIP_EN
  logic [X_W:0] w_xs;
  logic [Y_W:0] w_ys;
  assign w_xs = {1'b0, r_xb} + (X_W+1)'(w_cx);
  assign w_ys = {1'b0, r_yb} + (Y_W+1)'(w_cy);
  assign w_x  = w_xs[X_W-1:0];
  assign w_y  = w_ys[Y_W-1:0];
  assign w_on = (int'(w_xs) < SCREEN_W) && (int'(w_ys) < SCREEN_H);
`else
  assign w_x  = r_xb + X_W'(w_cx);
  assign w_y  = r_yb + Y_W'(w_cy);
  assign w_on = 1'b1;
`endif
  box_scan_counter u_scan (
    .clk    (clk),
    .rst_n  (reset),
    .i_clr  (w_accept),
    .i_en   (w_en),
    .i_n    (r_nb),
    .o_cx   (w_cx),
    .o_cy   (w_cy),
    .o_last (w_last)
  );
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  // next state: empty boxes skip straight to DONE
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == IDLE) ? (gobox ? ((Scalein != '0) ? DRAW : DONE) : IDLE) :
                  (r_state == DRAW) ? (w_last ? DONE : DRAW) : IDLE;
  end
  // request latch, registered pixel port and handshake outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_xb    <= '0;
      r_yb    <= '0;
      r_cb    <= '0;
      r_nb    <= '0;
      Xvga    <= '0;
      Yvga    <= '0;
      Clrvga  <= '0;
      plot    <= 1'b0;
      donebox <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_xb <= Xin;
        r_yb <= Yin;
        r_cb <= Clrin;
        r_nb <= Scalein;
        busy <= 1'b1;
      end
      if (r_state == DRAW) begin
        Xvga   <= w_x;
        Yvga   <= w_y;
        Clrvga <= r_cb;
      end
      plot    <= (r_state == DRAW) && w_on;
      donebox <= r_state == DONE;
      if (r_state == DONE) busy <= 1'b0;
    end
endmodule

// File: tb/tb_box_drawer.sv
// tb_box_drawer: directed and randomized checks of box_drawer against a pixel-list reference model
module tb_box_drawer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] Xin = '0;
  logic [6:0] Yin = '0;
  logic [2:0] Clrin = '0;
  logic [5:0] Scalein = '0;
  logic       gobox = 1'b0;
  logic       donebox, busy, plot;
  logic [7:0] Xvga;
  logic [6:0] Yvga;
  logic [2:0] Clrvga;
  int n_chk = 0;
  int n_pass = 0;

  box_drawer dut (
    .clk(clk), .reset(reset), .Xin(Xin), .Yin(Yin), .Clrin(Clrin), .Scalein(Scalein),
    .gobox(gobox), .donebox(donebox), .busy(busy), .Xvga(Xvga), .Yvga(Yvga),
    .Clrvga(Clrvga), .plot(plot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic visible(input int px, input int py);
`ifdef BOX_CLIP_EN
    return (px < 160) && (py < 120);
`else
    return 1'b1;
`endif
  endfunction

  task automatic start(input int x, input int y, input int c, input int n);
    @(negedge clk);
    Xin = 8'(x); Yin = 7'(y); Clrin = 3'(c); Scalein = 6'(n); gobox = 1'b1;
    @(posedge clk); #1;
    gobox = 1'b0;
    chk("accept_busy", 32'(busy), 1);
    chk("accept_plot", 32'(plot), 0);
    chk("accept_done", 32'(donebox), 0);
  endtask

  // mode 0: inputs untouched, 1: scramble inputs mid-box, 2: change Xin to nx mid-box
  task automatic expect_box(input int x, input int y, input int c, input int n,
                            input int mode, input logic [7:0] nx);
    for (int k = 0; k < n * n; k++) begin
      int px, py;
      @(posedge clk); #1;
      px = x + k % n;
      py = y + k / n;
      chk("pix_x", 32'(Xvga), px % 256);
      chk("pix_y", 32'(Yvga), py % 128);
      chk("pix_clr", 32'(Clrvga), c);
      chk("pix_plot", 32'(plot), 32'(visible(px, py)));
      chk("pix_busy", 32'(busy), 1);
      chk("pix_done", 32'(donebox), 0);
      if (mode == 1) begin
        Xin = 8'($urandom); Yin = 7'($urandom); Clrin = 3'($urandom); Scalein = 6'($urandom);
      end else if (mode == 2 && k == 0) Xin = nx;
    end
    @(posedge clk); #1;
    chk("done_pulse", 32'(donebox), 1);
    chk("done_plot", 32'(plot), 0);
    chk("done_busy", 32'(busy), 0);
  endtask

  initial begin
    @(posedge clk); #1;
    chk("rst_x", 32'(Xvga), 0);
    chk("rst_y", 32'(Yvga), 0);
    chk("rst_clr", 32'(Clrvga), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_done", 32'(donebox), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk); reset = 1'b1;
    // basic 3x3 box
    start(10, 20, 5, 3);
    expect_box(10, 20, 5, 3, 0, 8'd0);
    @(posedge clk); #1;
    chk("done_clear", 32'(donebox), 0);
    // empty box
    start(50, 60, 2, 0);
    expect_box(50, 60, 2, 0, 0, 8'd0);
    @(posedge clk); #1;
    chk("zero_clear", 32'(donebox), 0);
    chk("zero_plot", 32'(plot), 0);
    // edge-of-screen box
    start(158, 118, 6, 4);
    expect_box(158, 118, 6, 4, 0, 8'd0);
    // reset mid-draw
    start(7, 9, 2, 4);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_x", 32'(Xvga), 0);
    chk("mid_rst_y", 32'(Yvga), 0);
    chk("mid_rst_clr", 32'(Clrvga), 0);
    chk("mid_rst_plot", 32'(plot), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_done", 32'(donebox), 0);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_plot", 32'(plot), 0);
    end
    start(3, 4, 1, 2);
    expect_box(3, 4, 1, 2, 0, 8'd0);
    // back-to-back with gobox held and Xin changed mid-box
    @(negedge clk);
    Xin = 8'd30; Yin = 7'd40; Clrin = 3'd6; Scalein = 6'd2; gobox = 1'b1;
    @(posedge clk); #1;
    chk("b2b_busy1", 32'(busy), 1);
    expect_box(30, 40, 6, 2, 2, 8'd77);
    @(posedge clk); #1;
    chk("b2b_busy2", 32'(busy), 1);
    chk("b2b_done2", 32'(donebox), 0);
    chk("b2b_plot2", 32'(plot), 0);
    expect_box(77, 40, 6, 2, 0, 8'd0);
    gobox = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle_busy", 32'(busy), 0);
    chk("b2b_idle_done", 32'(donebox), 0);
    // randomized boxes, inputs scrambled while busy
    for (int i = 0; i < 24; i++) begin
      int x, y, c, n;
      x = (i % 2) ? int'($urandom_range(140, 255)) : int'($urandom_range(0, 255));
      y = (i % 3) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 127));
      c = int'($urandom_range(0, 7));
      n = int'($urandom_range(0, 10));
      start(x, y, c, n);
      expect_box(x, y, c, n, 1, 8'd0);
    end
    @(posedge clk); #1;
    chk("final_done", 32'(donebox), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
